// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the PC, drives the program ROM address,
// absorbs the ROM's one-cycle read latency and hands words to decode over valid/ready.
module fetch_sequencer #(
  parameter int AW       = 4,
  parameter int DW       = 4,
  parameter int RESET_PC = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          run,
  output logic [AW-1:0] addr_p,
  input  logic [DW-1:0] prom_data,
  output logic [DW-1:0] instr,
  output logic [AW-1:0] instr_pc,
  output logic          instr_valid,
  input  logic          instr_ready,
  input  logic          jump_en,
  input  logic [AW-1:0] jump_addr,
  input  logic          halt_req,
  output logic          halted
);

  localparam logic [AW-1:0] RST_PC = AW'(RESET_PC);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    CAPT   = 3'd2,
    VALID  = 3'd3,
    HALTED = 3'd4
  } state_t;

  state_t        state;
  logic [AW-1:0] pc;

  // ROM registers the address itself, so addr_p is a bare wire off the pc flop
  assign addr_p = pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      pc          <= RST_PC;
      instr       <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (run) state <= FETCH;
        end
        FETCH: begin
          state <= CAPT;
        end
        CAPT: begin
          instr       <= prom_data;
          instr_pc    <= pc;
          instr_valid <= 1'b1;
          pc          <= pc + AW'(1);
          state       <= VALID;
        end
        VALID: begin
          // jump/halt only mean something alongside the accepted word
          if (instr_ready) begin
            instr_valid <= 1'b0;
            if (jump_en) pc <= jump_addr;
            if (halt_req) begin
              halted <= 1'b1;
              state  <= HALTED;
            end else begin
              state  <= FETCH;
            end
          end
        end
        HALTED: begin
          if (run) begin
            halted <= 1'b0;
            state  <= FETCH;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
